reflet_mem_arbiter: RTL and testbench

//  Time-sliced arbiter that shares one reflet memory bus (ROM/RAM/testers with 1-cycle read latency)

---
 rtl/reflet_mem_arbiter_pkg.sv | 16 +
 rtl/reflet_mem_arbiter_if.sv | 46 ++++
 rtl/reflet_quantum_counter.sv | 34 +++
 rtl/reflet_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_reflet_mem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/reflet_mem_arbiter_pkg.sv
// Shared definitions for the reflet memory arbiter: FSM state type and
// the width helper for the ownership quantum counter.
package reflet_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SWITCH = 2'd1,
    ARB_OWN    = 2'd2
  } arb_state_t;

  // Counter must hold 0..quantum-1; a quantum of 1 still needs one bit.
  function automatic int cnt_width(input int q);
    return (q > 1) ? $clog2(q) : 1;
  endfunction

endpackage

// File: rtl/reflet_mem_arbiter_if.sv
// Bundle of the two master-side bus ports and the shared memory bus.
//  mX_req/addr/data_out/write_en : requests from master X
//  mX_enable/data_in             : run enable and read data back to master X
//  bus_addr/data_out/write_en    : shared memory bus towards the memory map
//  bus_data_in                   : OR-ed read data (valid one cycle after addr)
// The arbiter uses the slave view; masters and memories use the master view.
interface reflet_mem_arbiter_if #(
  parameter int wordsize = 16
);
  logic                m0_req;
  logic [wordsize-1:0] m0_addr;
  logic [wordsize-1:0] m0_data_out;
  logic                m0_write_en;
  logic                m0_enable;
  logic [wordsize-1:0] m0_data_in;

  logic                m1_req;
  logic [wordsize-1:0] m1_addr;
  logic [wordsize-1:0] m1_data_out;
  logic                m1_write_en;
  logic                m1_enable;
  logic [wordsize-1:0] m1_data_in;

  logic [wordsize-1:0] bus_addr;
  logic [wordsize-1:0] bus_data_out;
  logic                bus_write_en;
  logic [wordsize-1:0] bus_data_in;

  modport slave (
    input  m0_req, m0_addr, m0_data_out, m0_write_en,
    output m0_enable, m0_data_in,
    input  m1_req, m1_addr, m1_data_out, m1_write_en,
    output m1_enable, m1_data_in,
    output bus_addr, bus_data_out, bus_write_en,
    input  bus_data_in
  );

  modport master (
    output m0_req, m0_addr, m0_data_out, m0_write_en,
    input  m0_enable, m0_data_in,
    output m1_req, m1_addr, m1_data_out, m1_write_en,
    input  m1_enable, m1_data_in,
    input  bus_addr, bus_data_out, bus_write_en,
    output bus_data_in
  );
endinterface

// File: rtl/reflet_quantum_counter.sv
// Ownership-length counter for the arbiter.
//  clk, reset : clock, asynchronous active-low reset
//  clear      : force count to 0 (has priority over inc)
//  inc        : count up, saturating at quantum-1
//  expired    : count has reached quantum-1
module reflet_quantum_counter
  import reflet_mem_arbiter_pkg::*;
#(
  parameter int quantum = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int CW = cnt_width(quantum);
  localparam logic [CW-1:0] LIMIT = CW'(quantum - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/reflet_mem_arbiter.sv
// Time-sliced arbiter sharing one 1-cycle-latency reflet memory bus between
// two masters. The non-owner is stalled through its enable; read data is
// steered back to whichever master drove the address on the previous cycle.
//  clk   : system clock
//  reset : asynchronous active-low reset
//  arb   : master/bus signal bundle (slave view)
//  grant : current/incoming owner index
//  busy  : high whenever the arbiter is not idle
module reflet_mem_arbiter
  import reflet_mem_arbiter_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int quantum  = 8
) (
  input  logic                clk,
  input  logic                reset,
  reflet_mem_arbiter_if.slave arb,
  output logic                grant,
  output logic                busy
);
  arb_state_t state, state_next;
  logic       grant_next;
  logic       last_owner, last_owner_next;
  logic       owner_d, owner_d_valid;
  logic       expired;
  logic       own_req, other_req;

  reflet_quantum_counter #(.quantum(quantum)) u_quantum (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ARB_OWN),
    .inc     (state == ARB_OWN),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      grant         <= 1'b0;
      last_owner    <= 1'b1;
      owner_d       <= 1'b0;
      owner_d_valid <= 1'b0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      last_owner    <= last_owner_next;
      owner_d       <= grant;
      owner_d_valid <= (state != ARB_IDLE);
    end
  end

  assign own_req   = grant ? arb.m1_req : arb.m0_req;
  assign other_req = grant ? arb.m0_req : arb.m1_req;

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_owner_next = last_owner;
    unique case (state)
      ARB_IDLE: begin
        if (arb.m0_req && arb.m1_req) begin
          state_next = ARB_SWITCH;
          grant_next = ~last_owner;
        end else if (arb.m0_req) begin
          state_next = ARB_SWITCH;
          grant_next = 1'b0;
        end else if (arb.m1_req) begin
          state_next = ARB_SWITCH;
          grant_next = 1'b1;
        end
      end
      ARB_SWITCH: begin
        state_next = ARB_OWN;
      end
      ARB_OWN: begin
        // An owner drop takes precedence, so a drop on the expiry edge
        // resolves exactly like a plain drop.
        if (!own_req) begin
          last_owner_next = grant;
          if (other_req) begin
            state_next = ARB_SWITCH;
            grant_next = ~grant;
          end else begin
            state_next = ARB_IDLE;
          end
        end else if (expired && other_req) begin
          last_owner_next = grant;
          state_next      = ARB_SWITCH;
          grant_next      = ~grant;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Bus and enables are additionally gated by reset so an in-flight write
  // strobe is cut combinationally when reset asserts.
  always_comb begin
    arb.bus_addr     = '0;
    arb.bus_data_out = '0;
    arb.bus_write_en = 1'b0;
    arb.m0_enable    = 1'b0;
    arb.m1_enable    = 1'b0;
    if (reset) begin
      unique case (state)
        ARB_SWITCH: begin
          arb.bus_addr     = grant ? arb.m1_addr : arb.m0_addr;
          arb.bus_data_out = grant ? arb.m1_data_out : arb.m0_data_out;
        end
        ARB_OWN: begin
          arb.bus_addr     = grant ? arb.m1_addr : arb.m0_addr;
          arb.bus_data_out = grant ? arb.m1_data_out : arb.m0_data_out;
          arb.bus_write_en = grant ? arb.m1_write_en : arb.m0_write_en;
          arb.m0_enable    = ~grant;
          arb.m1_enable    = grant;
        end
        default: begin
        end
      endcase
    end
  end

  assign arb.m0_data_in = (owner_d_valid && !owner_d) ? arb.bus_data_in : '0;
  assign arb.m1_data_in = (owner_d_valid &&  owner_d) ? arb.bus_data_in : '0;

  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Bench for reflet_mem_arbiter: a small ROM/RAM with one-cycle read latency
// sits on the shared bus, a behavioural ownership model predicts every
// output on each falling edge, and directed steps pin key literal values.
module tb_reflet_mem_arbiter;
  localparam int WS = 16;
  localparam int Q  = 8;

  logic clk = 1'b0;
  logic reset;
  logic grant, busy;

  reflet_mem_arbiter_if #(.wordsize(WS)) arb ();

  reflet_mem_arbiter #(.wordsize(WS), .quantum(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'hC0DE ^ {11'd0, a[5:1]};
  endfunction

  // Memory on the shared bus: RAM at 0x8000.., ROM elsewhere.
  logic [15:0] ram [0:15];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    if (arb.bus_write_en && arb.bus_addr[15]) ram[arb.bus_addr[4:1]] <= arb.bus_data_out;
    rd_q <= arb.bus_addr[15] ? ram[arb.bus_addr[4:1]] : rom_word(arb.bus_addr);
  end
  assign arb.bus_data_in = rd_q;

  // Behavioural model: mode 0 idle, 1 turnaround, 2 owning.
  int          mode, runlen;
  bit          mo, mlast, pv, po;
  logic [15:0] mram [0:15];
  logic [15:0] mrd, mrd_n, ea, ed;
  logic        ewe, r0, r1, mine, other;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_bus_addr", arb.bus_addr, 0);
      chk("rst_bus_we", arb.bus_write_en, 0);
      chk("rst_en0", arb.m0_enable, 0);
      chk("rst_en1", arb.m1_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_din0", arb.m0_data_in, 0);
      chk("rst_din1", arb.m1_data_in, 0);
      mode = 0; mo = 1'b0; mlast = 1'b1; runlen = 0; pv = 1'b0; po = 1'b0;
    end else begin
      ea  = (mode == 0) ? 16'h0 : (mo ? arb.m1_addr : arb.m0_addr);
      ed  = (mode == 0) ? 16'h0 : (mo ? arb.m1_data_out : arb.m0_data_out);
      ewe = (mode == 2) ? (mo ? arb.m1_write_en : arb.m0_write_en) : 1'b0;
      chk("bus_addr", arb.bus_addr, ea);
      chk("bus_data_out", arb.bus_data_out, ed);
      chk("bus_we", arb.bus_write_en, ewe);
      chk("en0", arb.m0_enable, (mode == 2) && !mo);
      chk("en1", arb.m1_enable, (mode == 2) && mo);
      chk("busy", busy, mode != 0);
      chk("grant", grant, mo);
      chk("din0", arb.m0_data_in, (pv && !po) ? mrd : 16'h0);
      chk("din1", arb.m1_data_in, (pv && po) ? mrd : 16'h0);
      // advance to the next cycle
      r0 = arb.m0_req; r1 = arb.m1_req;
      mrd_n = ea[15] ? mram[ea[4:1]] : rom_word(ea);
      if (ewe && ea[15]) mram[ea[4:1]] = ed;
      mrd = mrd_n;
      pv = (mode != 0);
      po = mo;
      case (mode)
        0: begin
          if (r0 && r1) begin mo = !mlast; mode = 1; end
          else if (r0) begin mo = 1'b0; mode = 1; end
          else if (r1) begin mo = 1'b1; mode = 1; end
        end
        1: begin mode = 2; runlen = 1; end
        default: begin
          mine  = mo ? r1 : r0;
          other = mo ? r0 : r1;
          if (!mine) begin
            mlast = mo;
            if (other) begin mo = !mo; mode = 1; end
            else mode = 0;
          end else if (other && runlen >= Q) begin
            mlast = mo; mo = !mo; mode = 1;
          end else begin
            runlen++;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1);
  end

  int  c0, c1;
  bit  seen;

  initial begin
    for (int i = 0; i < 16; i++) begin ram[i] = '0; mram[i] = '0; end
    rd_q = '0; mrd = '0;
    reset = 1'b0;
    arb.m0_req = 1'b1; arb.m0_addr = 16'h8002; arb.m0_data_out = 16'h1234; arb.m0_write_en = 1'b1;
    arb.m1_req = 1'b1; arb.m1_addr = 16'h8004; arb.m1_data_out = 16'h5678; arb.m1_write_en = 1'b1;

    // reset held with both requesting
    repeat (3) step();
    chk("t1_rst_en0", arb.m0_enable, 0);
    chk("t1_rst_we", arb.bus_write_en, 0);
    chk("t1_rst_busy", busy, 0);
    reset = 1'b1;
    step();
    chk("t1_sw_grant", grant, 0);
    chk("t1_sw_en0", arb.m0_enable, 0);
    chk("t1_sw_addr", arb.bus_addr, 16'h8002);
    step();
    chk("t1_own_en0", arb.m0_enable, 1);
    chk("t1_own_en1", arb.m1_enable, 0);

    // m0 owns 8 cycles; on its last one it reads ROM 0
    repeat (7) step();
    chk("t3_ram1", ram[1], 16'h1234);
    chk("t3_ram2_untouched", ram[2], 16'h0000);
    arb.m0_addr = 16'h0000; arb.m0_write_en = 1'b0;
    step();
    chk("t4_sw_grant", grant, 1);
    chk("t4_sw_we", arb.bus_write_en, 0);
    chk("t4_din0", arb.m0_data_in, 16'hC0DE);
    chk("t4_din1", arb.m1_data_in, 16'h0000);
    step();
    chk("t3_m1_en", arb.m1_enable, 1);
    chk("t3_ram2_pre", ram[2], 16'h0000);
    step();
    chk("t3_ram2", ram[2], 16'h5678);
    arb.m1_write_en = 1'b0;

    // steady sharing: 8 owned cycles each per 18-cycle period
    c0 = 0; c1 = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      c0 += int'(arb.m0_enable);
      c1 += int'(arb.m1_enable);
    end
    chk("t2_duty0", c0, 8);
    chk("t2_duty1", c1, 8);

    // everyone drops: reach IDLE, then m1 alone for three cycles
    arb.m0_req = 1'b0; arb.m1_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (!busy) seen = 1'b1;
    end
    chk("t5_wait_idle", seen, 1);
    arb.m1_req = 1'b1;
    step();
    chk("t5_sw_grant", grant, 1);
    step(); step(); step();
    chk("t5_own3_en1", arb.m1_enable, 1);
    arb.m1_req = 1'b0;
    step();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_addr", arb.bus_addr, 16'h0000);
    chk("t5_idle_en1", arb.m1_enable, 0);

    // lone owner keeps the bus past the quantum, then yields at once
    arb.m0_req = 1'b1;
    step(); step();
    repeat (11) step();
    chk("sat_en0", arb.m0_enable, 1);
    arb.m1_req = 1'b1;
    step();
    chk("sat_sw_grant", grant, 1);

    // reset in the middle of an m1 write (last owner was m0)
    step();
    arb.m1_addr = 16'h8006; arb.m1_data_out = 16'hBEEF; arb.m1_write_en = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_mid_we", arb.bus_write_en, 0);
    chk("rst_mid_en1", arb.m1_enable, 0);
    chk("rst_mid_busy", busy, 0);
    arb.m1_write_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_restart_grant", grant, 0);

    // owner drops on its expiry cycle: treated as a plain drop
    step();
    repeat (7) step();
    arb.m0_req = 1'b0;
    step();
    chk("drop_exp_grant", grant, 1);
    chk("drop_exp_busy", busy, 1);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
